// File: rtl/auto_play_pkg.sv
// Shared definitions for the auto-play jukebox: note/octave codes, ROM entry layout,
// and the mid-octave frequency table used to derive tone half-periods.
package auto_play_pkg;

  localparam int OCT_W  = 2;
  localparam int NOTE_W = 3;
  localparam int DUR_W  = 3;
  localparam int IDX_W  = 4;   // longest song is 15 notes plus end marker
  localparam int TONE_W = 24;  // low C at 100 MHz needs 19 bits; headroom for faster clocks

  localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_C    = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_D    = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_E    = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_G    = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_A    = 3'd6;
  localparam logic [NOTE_W-1:0] NOTE_B    = 3'd7;

  localparam logic [OCT_W-1:0] OCT_LOW  = 2'd0;
  localparam logic [OCT_W-1:0] OCT_MID  = 2'd1;
  localparam logic [OCT_W-1:0] OCT_HIGH = 2'd2;

  // dur == 0 marks the end of a song
  typedef struct packed {
    logic [OCT_W-1:0]  oct;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  // Mid-octave frequencies in Hz, indexed by note code (0 = rest)
  localparam int unsigned MID_FREQ [8] = '{0, 262, 294, 330, 349, 392, 440, 494};

  function automatic int unsigned mid_half_period(input int unsigned clk_freq,
                                                  input logic [NOTE_W-1:0] n);
    return (n == NOTE_REST) ? 0 : clk_freq / (2 * MID_FREQ[n]);
  endfunction

  function automatic rom_entry_t mk(input logic [OCT_W-1:0] o, input logic [NOTE_W-1:0] n,
                                    input logic [DUR_W-1:0] d);
    rom_entry_t e;
    e.oct  = o;
    e.note = n;
    e.dur  = d;
    return e;
  endfunction

endpackage

// File: rtl/auto_play_tone_gen.sv
// Square-wave generator: toggles the speaker every half_period clocks while enabled.
// Clear (or disable) forces the counter and speaker back to 0 so each note starts in phase.
module tone_gen
  import auto_play_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [TONE_W-1:0] half_period_i,
  output logic              speaker_o
);

  logic [TONE_W-1:0] cnt_q;
  logic              spk_q;

  // Count to half_period-1, then toggle and wrap; idle/cleared state is low
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || !en_i) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else if (cnt_q == half_period_i - 1'b1) begin
      cnt_q <= '0;
      spk_q <= ~spk_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign speaker_o = spk_q;

endmodule

// File: rtl/auto_play.sv
// Auto-play jukebox: walks the note ROM of the selected song, holding each entry for
// dur beats, and drives a one-hot note LED plus a square-wave speaker.
module auto_play
  import auto_play_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,   // active-high despite the name
  input  logic [2:0] select,
  output logic [6:0] led,
  output logic       speaker
);

  localparam int BEAT_W = $clog2(7 * BEAT_CYCLES + 1);

  localparam logic [TONE_W-1:0] HP_MID [8] = '{
    TONE_W'(mid_half_period(CLK_FREQ, 3'd0)), TONE_W'(mid_half_period(CLK_FREQ, 3'd1)),
    TONE_W'(mid_half_period(CLK_FREQ, 3'd2)), TONE_W'(mid_half_period(CLK_FREQ, 3'd3)),
    TONE_W'(mid_half_period(CLK_FREQ, 3'd4)), TONE_W'(mid_half_period(CLK_FREQ, 3'd5)),
    TONE_W'(mid_half_period(CLK_FREQ, 3'd6)), TONE_W'(mid_half_period(CLK_FREQ, 3'd7))};

  function automatic logic song_valid(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
  endfunction

  // Hard-wired songs; anything past the last note (or an invalid song) reads as end-of-song
  function automatic rom_entry_t song_rom(input logic [2:0] song, input logic [IDX_W-1:0] idx);
    rom_entry_t e;
    e = '0;
    case (song)
      3'd1: case (idx)  // Twinkle
        4'd0:  e = mk(OCT_MID, NOTE_C, 3'd1);
        4'd1:  e = mk(OCT_MID, NOTE_C, 3'd1);
        4'd2:  e = mk(OCT_MID, NOTE_G, 3'd1);
        4'd3:  e = mk(OCT_MID, NOTE_G, 3'd1);
        4'd4:  e = mk(OCT_MID, NOTE_A, 3'd1);
        4'd5:  e = mk(OCT_MID, NOTE_A, 3'd1);
        4'd6:  e = mk(OCT_MID, NOTE_G, 3'd2);
        4'd7:  e = mk(OCT_MID, NOTE_F, 3'd1);
        4'd8:  e = mk(OCT_MID, NOTE_F, 3'd1);
        4'd9:  e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd10: e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd11: e = mk(OCT_MID, NOTE_D, 3'd1);
        4'd12: e = mk(OCT_MID, NOTE_D, 3'd1);
        4'd13: e = mk(OCT_MID, NOTE_C, 3'd2);
        default: e = '0;
      endcase
      3'd2: case (idx)  // Ode to Joy
        4'd0:  e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd1:  e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd2:  e = mk(OCT_MID, NOTE_F, 3'd1);
        4'd3:  e = mk(OCT_MID, NOTE_G, 3'd1);
        4'd4:  e = mk(OCT_MID, NOTE_G, 3'd1);
        4'd5:  e = mk(OCT_MID, NOTE_F, 3'd1);
        4'd6:  e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd7:  e = mk(OCT_MID, NOTE_D, 3'd1);
        4'd8:  e = mk(OCT_MID, NOTE_C, 3'd1);
        4'd9:  e = mk(OCT_MID, NOTE_C, 3'd1);
        4'd10: e = mk(OCT_MID, NOTE_D, 3'd1);
        4'd11: e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd12: e = mk(OCT_MID, NOTE_E, 3'd1);
        4'd13: e = mk(OCT_MID, NOTE_D, 3'd1);
        4'd14: e = mk(OCT_MID, NOTE_D, 3'd2);
        default: e = '0;
      endcase
      3'd3: case (idx)  // scale
        4'd0:  e = mk(OCT_MID,  NOTE_C, 3'd1);
        4'd1:  e = mk(OCT_MID,  NOTE_D, 3'd1);
        4'd2:  e = mk(OCT_MID,  NOTE_E, 3'd1);
        4'd3:  e = mk(OCT_MID,  NOTE_F, 3'd1);
        4'd4:  e = mk(OCT_MID,  NOTE_G, 3'd1);
        4'd5:  e = mk(OCT_MID,  NOTE_A, 3'd1);
        4'd6:  e = mk(OCT_MID,  NOTE_B, 3'd1);
        4'd7:  e = mk(OCT_HIGH, NOTE_C, 3'd2);
        default: e = '0;
      endcase
      default: e = '0;
    endcase
    return e;
  endfunction

  logic [2:0]        sel_q;
  logic              run_q;
  logic [IDX_W-1:0]  idx_q, idx_d, look_idx;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_last;
  rom_entry_t        cur_q, cur_d, look_e;
  logic [6:0]        led_q, led_d;
  logic              restart, advance, wrap, entry_chg;
  logic [TONE_W-1:0] hp_base, hp;

  // Sequencer: restart on reset release / select change / invalid song, else count beats
  // and step to the next entry, wrapping to entry 0 in the same cycle at the end marker
  always_comb begin
    restart   = !run_q || (select != sel_q) || !song_valid(select);
    beat_last = BEAT_W'(cur_q.dur) * BEAT_W'(BEAT_CYCLES) - BEAT_W'(1);
    advance   = !restart && (beat_q == beat_last);
    look_idx  = restart ? '0 : (advance ? idx_q + 1'b1 : idx_q);
    look_e    = song_rom(select, look_idx);
    wrap      = (look_e.dur == '0);
    idx_d     = wrap ? '0 : look_idx;
    cur_d     = wrap ? song_rom(select, '0) : look_e;
    beat_d    = (restart || advance) ? '0 : beat_q + 1'b1;
    entry_chg = restart || advance;
    led_d     = (cur_d.note == NOTE_REST) ? 7'd0 : (7'd1 << (cur_d.note - 3'd1));
  end

  // Player state and registered LED; select is sampled every cycle, reset included
  always_ff @(posedge clk) begin
    sel_q <= select;
    if (rst_n) begin
      run_q  <= 1'b0;
      idx_q  <= '0;
      beat_q <= '0;
      cur_q  <= '0;
      led_q  <= '0;
    end else begin
      run_q  <= 1'b1;
      idx_q  <= idx_d;
      beat_q <= beat_d;
      cur_q  <= cur_d;
      led_q  <= led_d;
    end
  end

  // Half-period for the current note, scaled by octave
  always_comb begin
    hp_base = HP_MID[cur_q.note];
    case (cur_q.oct)
      OCT_LOW:  hp = hp_base << 1;
      OCT_HIGH: hp = hp_base >> 1;
      default:  hp = hp_base;
    endcase
  end

  tone_gen u_tone (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .clear_i       (entry_chg),
    .en_i          (cur_q.note != NOTE_REST),
    .half_period_i (hp),
    .speaker_o     (speaker)
  );

  assign led = led_q;

endmodule

// File: tb/tb_auto_play.sv
// Directed bench for auto_play at 1 MHz. The beat is shortened to 2000 cycles so whole
// songs fit in a short run while notes still last longer than one tone half-period.
module tb_auto_play;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] select;
  logic [6:0] led;
  logic       speaker;

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;
  int bad;

  localparam logic [6:0] L_C = 7'b0000001, L_D = 7'b0000010, L_E = 7'b0000100,
                         L_F = 7'b0001000, L_G = 7'b0010000, L_B = 7'b1000000;

  auto_play #(.CLK_FREQ(1_000_000), .BEAT_CYCLES(2000)) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .led(led), .speaker(speaker)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Advance to cycle 'target' counted in negedges from the last reference point
  task automatic wait_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic hold_silent(input int n);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (led !== 7'd0 || speaker !== 1'b0) bad++;
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    select = 3'd1;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_spk", 32'(speaker), 32'd0);

    // Song 1: first clock after release shows C
    rst_n = 1'b0;
    @(negedge clk); t = 0;
    chk("s1_first_led", 32'(led), 32'(L_C));
    wait_to(1907); chk("s1_c_spk_lo", 32'(speaker), 32'd0);
    wait_to(1908); chk("s1_c_spk_hi", 32'(speaker), 32'd1);
    wait_to(1999); chk("s1_c_spk_hold", 32'(speaker), 32'd1);
    wait_to(2000); chk("s1_e1_led", 32'(led), 32'(L_C));
                   chk("s1_e1_spk_clr", 32'(speaker), 32'd0);
    wait_to(3999); chk("s1_e1_end_led", 32'(led), 32'(L_C));
    wait_to(4000); chk("s1_g_led", 32'(led), 32'(L_G));
    wait_to(5274); chk("s1_g_spk_lo", 32'(speaker), 32'd0);
    wait_to(5275); chk("s1_g_spk_hi", 32'(speaker), 32'd1);
    wait_to(27999); chk("s1_d_led", 32'(led), 32'(L_D));
    wait_to(28000); chk("s1_last_c_led", 32'(led), 32'(L_C));
    wait_to(32000); chk("s1_wrap_led", 32'(led), 32'(L_C));
                    chk("s1_wrap_spk", 32'(speaker), 32'd0);
    wait_to(33907); chk("s1_wrap_tone_lo", 32'(speaker), 32'd0);
    wait_to(33908); chk("s1_wrap_tone_hi", 32'(speaker), 32'd1);
    wait_to(34000); chk("s1_wrap_e1_led", 32'(led), 32'(L_C));

    // Switch to song 3 mid-note: restart at entry 0 with a fresh tone counter
    wait_to(35500);
    select = 3'd3;
    @(negedge clk); t = 0;
    chk("s3_start_led", 32'(led), 32'(L_C));
    chk("s3_start_spk", 32'(speaker), 32'd0);
    wait_to(1907);  chk("s3_c_spk_lo", 32'(speaker), 32'd0);
    wait_to(1908);  chk("s3_c_spk_hi", 32'(speaker), 32'd1);
    wait_to(2000);  chk("s3_d_led", 32'(led), 32'(L_D));
    wait_to(12000); chk("s3_b_led", 32'(led), 32'(L_B));
    wait_to(14000); chk("s3_hic_led", 32'(led), 32'(L_C));
    wait_to(14953); chk("s3_hic_spk_lo", 32'(speaker), 32'd0);
    wait_to(14954); chk("s3_hic_spk_hi", 32'(speaker), 32'd1);
    wait_to(15907); chk("s3_hic_spk_hold", 32'(speaker), 32'd1);
    wait_to(15908); chk("s3_hic_spk_fall", 32'(speaker), 32'd0);
    wait_to(17999); chk("s3_hic_end_led", 32'(led), 32'(L_C));
    wait_to(18000); chk("s3_wrap_led", 32'(led), 32'(L_C));

    // Invalid selects are silent
    select = 3'd0;
    @(negedge clk);
    chk("sel0_led", 32'(led), 32'd0);
    chk("sel0_spk", 32'(speaker), 32'd0);
    hold_silent(3000); chk("sel0_hold", 32'(bad), 32'd0);
    select = 3'd5;
    hold_silent(3000); chk("sel5_hold", 32'(bad), 32'd0);

    // Song 2 from entry 0
    select = 3'd2;
    @(negedge clk); t = 0;
    chk("s2_start_led", 32'(led), 32'(L_E));
    wait_to(4000);  chk("s2_f_led", 32'(led), 32'(L_F));
    wait_to(10000); chk("s2_e5_led", 32'(led), 32'(L_F));
    wait_to(11500); chk("s2_e5_spk", 32'(speaker), 32'd1);

    // Reset in the middle of entry 5
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_spk", 32'(speaker), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); t = 0;
    chk("s2_restart_led", 32'(led), 32'(L_E));
    wait_to(1514); chk("s2_e_spk_lo", 32'(speaker), 32'd0);
    wait_to(1515); chk("s2_e_spk_hi", 32'(speaker), 32'd1);
    wait_to(2000); chk("s2_e1_led", 32'(led), 32'(L_E));
    wait_to(4000); chk("s2_e2_led", 32'(led), 32'(L_F));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
